// File: rtl/ula_op_sequencer.sv
// Purpose: control sequencer ahead of the ALU-ops block. It owns the data-stack depth and TOS pointer,
//          fetches operands, drives SEL_ULA and writes the result back at the new top of stack.
// Latency: accept->OP_DONE is BIN 5, UN 3, PUSH 1 and error 1 cycle(s).
// Backpressure: OP_READY is high only in IDLE. The requester holds OP_VALID until accepted.
//
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   OP_VALID/OP_READY/OP_CODE/OP_DATA   request handshake and payload
//   OP_DONE/OP_ERR               completion pulse and under/overflow flag
//   STACK_ADDR/WE/WDATA/RDATA    data-stack RAM port; RDATA arrives 1 cycle after ADDR
//   OPND_DATA, CTRL_*, SEL_ULA   controls toward the ALU-ops block
//   TOS_OUT                      address of the top item (depth-1, so it wraps to all-ones when the stack is empty)
//   ULA_RESULT                   ALU-ops result fed back for write-back
module ula_op_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  OP_VALID,
    output logic                  OP_READY,
    input  logic [3:0]            OP_CODE,
    input  logic [DATA_WIDTH-1:0] OP_DATA,
    output logic                  OP_DONE,
    output logic                  OP_ERR,
    output logic [ADDR_WIDTH-1:0] STACK_ADDR,
    output logic                  STACK_WE,
    output logic [DATA_WIDTH-1:0] STACK_WDATA,
    input  logic [DATA_WIDTH-1:0] STACK_RDATA,
    output logic [DATA_WIDTH-1:0] OPND_DATA,
    output logic                  CTRL_REG_OP1,
    output logic                  CTRL_REG_OP2,
    output logic                  CTRL_REG_OVERFLOW,
    output logic                  CTRL_STACK_COMP,
    output logic [3:0]            SEL_ULA,
    output logic [ADDR_WIDTH-1:0] TOS_OUT,
    input  logic [DATA_WIDTH-1:0] ULA_RESULT
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD1, S_LD1, S_RD2, S_LD2, S_EXEC, S_PUSH, S_ERR
    } state_t;

    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   depth, depth_nxt;
    logic [ADDR_WIDTH-1:0] depth_lo;
    logic [3:0]            code_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  req_push, req_un, req_fail;

    assign depth_lo = depth[ADDR_WIDTH-1:0];
    assign TOS_OUT  = depth_lo - ADDR_WIDTH'(1);
    assign OPND_DATA = STACK_RDATA;
    assign OP_READY  = (state == S_IDLE);

    // Stack legality is judged on the incoming opcode, before anything is latched.
    assign req_push = (OP_CODE == 4'hF);
    assign req_un   = (OP_CODE == 4'h8);
    always_comb begin
        if (req_push)
            req_fail = (depth == CAPACITY);
        else if (req_un)
            req_fail = (depth == '0);
        else
            req_fail = (depth < (ADDR_WIDTH+1)'(2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            depth  <= '0;
            code_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            depth <= depth_nxt;
            if (OP_VALID && OP_READY) begin
                code_q <= OP_CODE;
                data_q <= OP_DATA;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        depth_nxt = depth;
        case (state)
            S_IDLE: begin
                if (OP_VALID) begin
                    if (req_fail)      state_nxt = S_ERR;
                    else if (req_push) state_nxt = S_PUSH;
                    else               state_nxt = S_RD1;
                end
            end
            S_RD1: state_nxt = S_LD1;
            S_LD1: state_nxt = (code_q == 4'h8) ? S_EXEC : S_RD2;
            S_RD2: state_nxt = S_LD2;
            S_LD2: begin
                // Two operands consumed and one result produced: the stack shrinks by one.
                state_nxt = S_EXEC;
                depth_nxt = depth - (ADDR_WIDTH+1)'(1);
            end
            S_EXEC: state_nxt = S_IDLE;
            S_PUSH: begin
                state_nxt = S_IDLE;
                depth_nxt = depth + (ADDR_WIDTH+1)'(1);
            end
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        OP_DONE           = 1'b0;
        OP_ERR            = 1'b0;
        STACK_ADDR        = '0;
        STACK_WE          = 1'b0;
        STACK_WDATA       = '0;
        CTRL_REG_OP1      = 1'b0;
        CTRL_REG_OP2      = 1'b0;
        CTRL_REG_OVERFLOW = 1'b0;
        CTRL_STACK_COMP   = 1'b0;
        SEL_ULA           = '0;
        case (state)
            S_RD1: begin
                STACK_ADDR = TOS_OUT;
                SEL_ULA    = code_q;
            end
            S_LD1: begin
                STACK_ADDR   = TOS_OUT;
                CTRL_REG_OP1 = 1'b1;
                SEL_ULA      = code_q;
            end
            S_RD2: begin
                STACK_ADDR = depth_lo - ADDR_WIDTH'(2);
                SEL_ULA    = code_q;
            end
            S_LD2: begin
                STACK_ADDR   = depth_lo - ADDR_WIDTH'(2);
                CTRL_REG_OP2 = 1'b1;
                SEL_ULA      = code_q;
            end
            S_EXEC: begin
                // The depth has already been updated, so TOS_OUT is the destination slot.
                OP_DONE    = 1'b1;
                STACK_ADDR = TOS_OUT;
                SEL_ULA    = code_q;
                if (code_q <= 4'h8) begin
                    STACK_WE          = 1'b1;
                    STACK_WDATA       = ULA_RESULT;
                    CTRL_REG_OVERFLOW = (code_q <= 4'h4);
                end else begin
                    // Compares only update the compare stack. The data slot keeps the old value.
                    CTRL_STACK_COMP = 1'b1;
                end
            end
            S_PUSH: begin
                OP_DONE     = 1'b1;
                STACK_ADDR  = depth_lo;
                STACK_WE    = 1'b1;
                STACK_WDATA = data_q;
            end
            S_ERR: begin
                OP_DONE = 1'b1;
                OP_ERR  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Purpose: self-checking bench for ula_op_sequencer. It uses a RAM model, an ALU-ops stub and a
//          stack-level reference model. A second DUT instance with ADDR_WIDTH=2 tests the full-stack limit.
module tb_ula_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- main instance (default parameters) ----------------
    logic        op_valid = 1'b0;
    logic [3:0]  op_code = '0;
    logic [7:0]  op_data = '0;
    logic        op_ready, op_done, op_err, stack_we;
    logic [11:0] stack_addr, tos_out;
    logic [7:0]  stack_wdata, stack_rdata, opnd_data, ula_result;
    logic        c_op1, c_op2, c_ovf, c_comp;
    logic [3:0]  sel_ula;

    ula_op_sequencer u_dut (
        .clk(clk), .rst_n(rst_n),
        .OP_VALID(op_valid), .OP_READY(op_ready), .OP_CODE(op_code), .OP_DATA(op_data),
        .OP_DONE(op_done), .OP_ERR(op_err),
        .STACK_ADDR(stack_addr), .STACK_WE(stack_we), .STACK_WDATA(stack_wdata),
        .STACK_RDATA(stack_rdata), .OPND_DATA(opnd_data),
        .CTRL_REG_OP1(c_op1), .CTRL_REG_OP2(c_op2),
        .CTRL_REG_OVERFLOW(c_ovf), .CTRL_STACK_COMP(c_comp),
        .SEL_ULA(sel_ula), .TOS_OUT(tos_out), .ULA_RESULT(ula_result)
    );

    // ---------------- small instance (capacity 4) ----------------
    logic       s_valid = 1'b0;
    logic [3:0] s_code = '0;
    logic [7:0] s_data = '0;
    logic [7:0] s_rdata = '0;
    logic [7:0] s_ula = '0;
    logic       s_ready, s_done, s_err, s_we, s_op1, s_op2, s_ovf, s_comp;
    logic [1:0] s_addr, s_tos;
    logic [7:0] s_wdata, s_opnd;
    logic [3:0] s_sel;

    ula_op_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) u_small (
        .clk(clk), .rst_n(rst_n),
        .OP_VALID(s_valid), .OP_READY(s_ready), .OP_CODE(s_code), .OP_DATA(s_data),
        .OP_DONE(s_done), .OP_ERR(s_err),
        .STACK_ADDR(s_addr), .STACK_WE(s_we), .STACK_WDATA(s_wdata),
        .STACK_RDATA(s_rdata), .OPND_DATA(s_opnd),
        .CTRL_REG_OP1(s_op1), .CTRL_REG_OP2(s_op2),
        .CTRL_REG_OVERFLOW(s_ovf), .CTRL_STACK_COMP(s_comp),
        .SEL_ULA(s_sel), .TOS_OUT(s_tos), .ULA_RESULT(s_ula)
    );

    // ALU behaviour: a = IN_1 (top), b = IN_2 (next).
    function automatic logic [7:0] alu_f(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
        case (sel)
            4'd0:  return b + a;
            4'd1:  return b - a;
            4'd2:  return b & a;
            4'd3:  return b | a;
            4'd4:  return b ^ a;
            4'd5:  return {b[6:0], b[7]};
            4'd6:  return b * a;
            4'd7:  return (b > a) ? b : a;
            4'd8:  return ~a;
            4'd9:  return 8'(b == a);
            4'd10: return 8'(b != a);
            4'd11: return 8'(b > a);
            4'd12: return 8'(b < a);
            4'd13: return 8'(b >= a);
            4'd14: return 8'(b <= a);
            default: return 8'h00;
        endcase
    endfunction

    // Data-stack RAM with registered read, and the ALU-ops operand registers.
    logic [7:0] mem [0:4095];
    logic [7:0] r1 = '0, r2 = '0;
    initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    initial stack_rdata = '0;
    always @(posedge clk) begin
        if (stack_we) mem[stack_addr] <= stack_wdata;
        stack_rdata <= mem[stack_addr];
        if (c_op1) r1 <= opnd_data;
        if (c_op2) r2 <= opnd_data;
    end
    assign ula_result = alu_f(sel_ula, r1, r2);

    // Reference stack model.
    logic [7:0] stk [0:4095];
    int depth_m = 0;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        op_valid = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        depth_m = 0;
    endtask

    task automatic do_op(input logic [3:0] code, input logic [7:0] data);
        logic exp_err, exp_we, exp_ovf, exp_comp, is_push, is_un;
        logic [11:0] exp_addr;
        logic [7:0] exp_wdata, res;
        int exp_lat, new_d, lat, we_cnt, ovf_cnt, comp_cnt, op1_cnt, op2_cnt, sel_bad, guard;
        logic obs_err;
        logic [11:0] obs_addr, obs_tos;
        logic [7:0] obs_wdata;
        logic mem_ok;
        is_push = (code == 4'hF);
        is_un   = (code == 4'h8);
        exp_err = is_push ? (depth_m >= 4096) : (is_un ? (depth_m < 1) : (depth_m < 2));
        exp_lat = (exp_err || is_push) ? 1 : (is_un ? 3 : 5);
        exp_we = 1'b0; exp_ovf = 1'b0; exp_comp = 1'b0; exp_addr = '0; exp_wdata = '0; res = '0;
        new_d = depth_m;
        if (!exp_err) begin
            if (is_push) begin
                exp_we = 1'b1; exp_addr = 12'(depth_m); exp_wdata = data; new_d = depth_m + 1;
            end else begin
                res = alu_f(code, stk[depth_m-1], is_un ? 8'h00 : stk[depth_m-2]);
                new_d = is_un ? depth_m : depth_m - 1;
                exp_addr = 12'(new_d - 1);
                exp_we = (code <= 4'd8);
                exp_wdata = res;
                exp_ovf = (code <= 4'd4);
                exp_comp = (code >= 4'd9);
            end
        end
        @(negedge clk);
        guard = 0;
        while (!op_ready && guard < 20) begin @(negedge clk); guard++; end
        total++;
        if (op_ready !== 1'b1) begin bad++; $display("FAIL ready_wait: op_ready=%b required 1", op_ready); end
        op_valid = 1'b1; op_code = code; op_data = data;
        @(negedge clk);
        op_valid = 1'b0; op_code = $urandom_range(0, 15); op_data = 8'($urandom);
        lat = 1; we_cnt = 0; ovf_cnt = 0; comp_cnt = 0; op1_cnt = 0; op2_cnt = 0; sel_bad = 0;
        obs_addr = '0; obs_wdata = '0; obs_err = 1'b0; obs_tos = '0;
        forever begin
            if (stack_we) begin we_cnt++; obs_addr = stack_addr; obs_wdata = stack_wdata; end
            if (c_ovf) ovf_cnt++;
            if (c_comp) comp_cnt++;
            if (c_op1) op1_cnt++;
            if (c_op2) op2_cnt++;
            if (!is_push && !exp_err && sel_ula !== code) sel_bad++;
            if (op_done || lat >= 10) begin
                obs_err = op_err;
                obs_tos = tos_out;
                if (!stack_we) obs_addr = stack_addr;
                break;
            end
            @(negedge clk);
            lat++;
        end
        total++; if (lat != exp_lat) begin bad++; $display("FAIL latency op=%0d: got %0d required %0d", code, lat, exp_lat); end
        total++; if (obs_err !== exp_err) begin bad++; $display("FAIL op_err op=%0d: got %b required %b", code, obs_err, exp_err); end
        total++; if (we_cnt != int'(exp_we)) begin bad++; $display("FAIL we_count op=%0d: got %0d required %0d", code, we_cnt, exp_we); end
        total++; if (ovf_cnt != int'(exp_ovf)) begin bad++; $display("FAIL ovf_count op=%0d: got %0d required %0d", code, ovf_cnt, exp_ovf); end
        total++; if (comp_cnt != int'(exp_comp)) begin bad++; $display("FAIL comp_count op=%0d: got %0d required %0d", code, comp_cnt, exp_comp); end
        total++; if (op1_cnt != ((exp_err || is_push) ? 0 : 1)) begin bad++; $display("FAIL op1_count op=%0d: got %0d", code, op1_cnt); end
        total++; if (op2_cnt != ((exp_err || is_push || is_un) ? 0 : 1)) begin bad++; $display("FAIL op2_count op=%0d: got %0d", code, op2_cnt); end
        total++; if (sel_bad != 0) begin bad++; $display("FAIL sel_hold op=%0d: %0d cycles with wrong SEL_ULA", code, sel_bad); end
        if (!exp_err) begin
            total++; if (obs_addr !== exp_addr) begin bad++; $display("FAIL addr op=%0d: got %0d required %0d", code, obs_addr, exp_addr); end
            if (exp_we) begin
                total++; if (obs_wdata !== exp_wdata) begin bad++; $display("FAIL wdata op=%0d: got %0d required %0d", code, obs_wdata, exp_wdata); end
            end
            if (!is_push) begin
                total++; if (obs_tos !== exp_addr) begin bad++; $display("FAIL tos_exec op=%0d: got %0d required %0d", code, obs_tos, exp_addr); end
            end
        end
        // Update the model at stack level.
        if (!exp_err) begin
            if (is_push) stk[depth_m] = data;
            else if (exp_we) stk[new_d-1] = res;
            depth_m = new_d;
        end
        @(negedge clk);
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL ready_after op=%0d: got %b required 1", code, op_ready); end
        total++; if (tos_out !== 12'(depth_m - 1)) begin bad++; $display("FAIL tos_idle op=%0d: got %0d required %0d", code, tos_out, 12'(depth_m - 1)); end
        mem_ok = 1'b1;
        for (int i = 0; i < depth_m; i++) if (mem[i] !== stk[i]) mem_ok = 1'b0;
        total++; if (!mem_ok) begin bad++; $display("FAIL stack_contents after op=%0d: RAM differs from model (depth %0d)", code, depth_m); end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (op_ready !== 1'b1 || tos_out !== 12'hFFF || op_done !== 1'b0 || op_err !== 1'b0 ||
            stack_we !== 1'b0 || stack_addr !== 12'h000 || sel_ula !== 4'h0 || c_op1 !== 1'b0 ||
            c_op2 !== 1'b0 || c_ovf !== 1'b0 || c_comp !== 1'b0 || stack_wdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: ready=%b tos=%h done=%b err=%b we=%b addr=%h sel=%h required ready=1 tos=fff rest 0",
                     op_ready, tos_out, op_done, op_err, stack_we, stack_addr, sel_ula);
        end
        @(negedge clk);
        rst_n = 1'b1;
        depth_m = 0;
    endtask

    task automatic test_empty_err();
        do_op(4'd0, 8'h00);
        do_op(4'd8, 8'h00);
        do_op(4'hF, 8'h0F);
        do_op(4'd8, 8'h00);
        total++; if (mem[0] !== 8'hF0) begin bad++; $display("FAIL not_0f: slot0=%h required f0", mem[0]); end
    endtask

    task automatic test_sub();
        do_reset();
        do_op(4'hF, 8'd5); do_op(4'hF, 8'd3); do_op(4'd1, 8'd0);
        total++; if (mem[0] !== 8'd2 || tos_out !== 12'd0) begin bad++; $display("FAIL sub_5_3: slot0=%0d tos=%0d required 2 and 0", mem[0], tos_out); end
    endtask

    task automatic test_add_ovf();
        do_reset();
        do_op(4'hF, 8'd200); do_op(4'hF, 8'd100); do_op(4'd0, 8'd0);
        total++; if (mem[0] !== 8'd44) begin bad++; $display("FAIL add_200_100: slot0=%0d required 44", mem[0]); end
    endtask

    task automatic test_compare();
        do_reset();
        do_op(4'hF, 8'd7); do_op(4'hF, 8'd3); do_op(4'd11, 8'd0);
        total++; if (mem[0] !== 8'd7 || tos_out !== 12'd0) begin bad++; $display("FAIL greater_7_3: slot0=%0d tos=%0d required 7 and 0", mem[0], tos_out); end
    endtask

    task automatic test_mid_reset();
        int guard, we_seen;
        logic [7:0] m0, m1;
        do_reset();
        do_op(4'hF, 8'd11); do_op(4'hF, 8'd22);
        m0 = mem[0]; m1 = mem[1];
        op_valid = 1'b1; op_code = 4'd0;
        @(negedge clk);
        op_valid = 1'b0;
        guard = 0;
        while (!c_op1 && guard < 10) begin @(negedge clk); guard++; end
        total++; if (c_op1 !== 1'b1) begin bad++; $display("FAIL mid_reset_ld1: never reached LD1"); end
        rst_n = 1'b0;
        #1;
        total++;
        if (op_ready !== 1'b1 || tos_out !== 12'hFFF || stack_we !== 1'b0 || op_done !== 1'b0) begin
            bad++; $display("FAIL mid_reset_state: ready=%b tos=%h we=%b done=%b required 1 fff 0 0", op_ready, tos_out, stack_we, op_done);
        end
        we_seen = 0;
        repeat (2) begin @(negedge clk); if (stack_we) we_seen++; end
        rst_n = 1'b1;
        depth_m = 0;
        repeat (2) begin @(negedge clk); if (stack_we) we_seen++; end
        total++; if (we_seen != 0 || mem[0] !== m0 || mem[1] !== m1) begin bad++; $display("FAIL mid_reset_nowrite: we=%0d slot0=%0d slot1=%0d", we_seen, mem[0], mem[1]); end
        total++; if (op_ready !== 1'b1 || tos_out !== 12'hFFF) begin bad++; $display("FAIL mid_reset_release: ready=%b tos=%h required 1 fff", op_ready, tos_out); end
        // A new operation still sees an empty stack.
        do_op(4'd0, 8'd0);
    endtask

    task automatic test_random();
        logic [3:0] c;
        for (int n = 0; n < 120; n++) begin
            c = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) c = 4'hF;
            do_op(c, 8'($urandom));
        end
    endtask

    task automatic s_op(input logic [3:0] code, input logic [7:0] data, input logic exp_err, input logic [1:0] exp_tos);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!s_ready && guard < 20) begin @(negedge clk); guard++; end
        s_valid = 1'b1; s_code = code; s_data = data;
        @(negedge clk);
        s_valid = 1'b0;
        guard = 0;
        while (!s_done && guard < 10) begin @(negedge clk); guard++; end
        total++; if (s_done !== 1'b1 || s_err !== exp_err) begin bad++; $display("FAIL small_err op=%0d: done=%b err=%b required 1 %b", code, s_done, s_err, exp_err); end
        @(negedge clk);
        total++; if (s_tos !== exp_tos) begin bad++; $display("FAIL small_tos op=%0d: got %0d required %0d", code, s_tos, exp_tos); end
    endtask

    task automatic test_small_full();
        do_reset();
        for (int i = 0; i < 4; i++) s_op(4'hF, 8'(i), 1'b0, 2'(i));
        s_op(4'hF, 8'h55, 1'b1, 2'd3);
        s_op(4'd0, 8'h00, 1'b0, 2'd2);
        s_op(4'hF, 8'h66, 1'b0, 2'd3);
    endtask

    initial begin
        test_reset();
        test_empty_err();
        test_sub();
        test_add_ovf();
        test_compare();
        test_mid_reset();
        test_random();
        test_small_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
